// File: rtl/issue_queue_if.sv
// Decode, score-board and execute-bus signals of the dual-issue queue.
// The slave modport is the queue; the master modport is its environment.
interface issue_queue_if #(
   parameter int REG_ADDR = 5,
   parameter int POS_W    = 8
);
   logic [1:0]                     in_valid;
   logic                           in_ready;
   logic [1:0][REG_ADDR-1:0]       in_dest;
   logic [1:0]                     in_wr;
   logic [1:0][1:0][REG_ADDR-1:0]  in_src;
   logic [1:0][2:0]                in_lat;
   logic [1:0][63:0]               in_payload;
   logic [3:0][REG_ADDR-1:0]       sb_read_addr;
   logic [3:0][POS_W-1:0]          sb_data_out;
   logic [1:0]                     sb_write_ena;
   logic [1:0][REG_ADDR-1:0]       sb_write_addr;
   logic [1:0][POS_W-1:0]          sb_data_in;
   logic [1:0]                     out_valid;
   logic [1:0][63:0]               out_payload;

   modport slave (
      input  in_valid, in_dest, in_wr, in_src, in_lat, in_payload, sb_data_out,
      output in_ready, sb_read_addr, sb_write_ena, sb_write_addr, sb_data_in,
             out_valid, out_payload
   );

   modport master (
      output in_valid, in_dest, in_wr, in_src, in_lat, in_payload, sb_data_out,
      input  in_ready, sb_read_addr, sb_write_ena, sb_write_addr, sb_data_in,
             out_valid, out_payload
   );
endinterface

// File: rtl/issue_queue.sv
// Dual-issue in-order instruction buffer with score-board hazard gate.
// Holds DEPTH decoded instructions and issues the oldest one or two per cycle.
module issue_queue #(
   parameter int DEPTH    = 4,
   parameter int POS_W    = 8,
   parameter int FWD_LVL  = 1,
   parameter int REG_ADDR = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          stall,
   input  logic          flash,
   issue_queue_if.slave  bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [REG_ADDR-1:0]      dest;
      logic                     wr;
      logic [1:0][REG_ADDR-1:0] src;
      logic [2:0]               lat;
      logic [63:0]              payload;
   } entry_t;

   entry_t             mem [DEPTH];
   logic [PTR_W-1:0]   head, tail;
   logic [CNT_W-1:0]   count;
   entry_t             q0, q1, e0, e1;
   logic [3:0]         src_ok;
   logic               ready, raw, iss0, iss1, enq, enq2;
   logic [1:0]         n_enq, n_deq;
   logic [2:0]         sh0, sh1;

   assign q0 = mem[head];
   assign q1 = mem[head + PTR_W'(1)];
   assign e0 = '{dest: bus.in_dest[0], wr: bus.in_wr[0], src: bus.in_src[0],
                 lat: bus.in_lat[0], payload: bus.in_payload[0]};
   assign e1 = '{dest: bus.in_dest[1], wr: bus.in_wr[1], src: bus.in_src[1],
                 lat: bus.in_lat[1], payload: bus.in_payload[1]};

   // in_ready reflects occupancy before this cycle's issue; forced high in reset
   assign ready        = !rst_n || (count <= CNT_W'(DEPTH - 2));
   assign bus.in_ready = ready;
   assign bus.sb_read_addr = {q1.src[1], q1.src[0], q0.src[1], q0.src[0]};

   always_comb begin
      for (int i = 0; i < 4; i++)
         src_ok[i] = (bus.sb_read_addr[i] == '0) || ((bus.sb_data_out[i] >> FWD_LVL) == '0);
   end

   assign raw  = q0.wr && (q0.dest != '0) && ((q0.dest == q1.src[0]) || (q0.dest == q1.src[1]));
   assign iss0 = rst_n && !stall && !flash && (count != '0) && src_ok[0] && src_ok[1];
   assign iss1 = iss0 && (count >= CNT_W'(2)) && src_ok[2] && src_ok[3] && !raw;

   assign sh0 = q0.lat - 3'd1;
   assign sh1 = q1.lat - 3'd1;

   // Same-dest pairs drive both ports; the score board lets slot 1 win.
   always_comb begin
      bus.sb_write_ena  = '0;
      bus.sb_write_addr = '0;
      bus.sb_data_in    = '0;
      if (iss0 && q0.wr && (q0.dest != '0)) begin
         bus.sb_write_ena[0]  = 1'b1;
         bus.sb_write_addr[0] = q0.dest;
         bus.sb_data_in[0]    = POS_W'(1) << sh0;
      end
      if (iss1 && q1.wr && (q1.dest != '0)) begin
         bus.sb_write_ena[1]  = 1'b1;
         bus.sb_write_addr[1] = q1.dest;
         bus.sb_data_in[1]    = POS_W'(1) << sh1;
      end
   end

   assign enq   = rst_n && !flash && ready && bus.in_valid[0];
   assign enq2  = enq && bus.in_valid[1];
   assign n_enq = enq2 ? 2'd2 : {1'b0, enq};
   assign n_deq = iss1 ? 2'd2 : {1'b0, iss0};

   always_ff @(posedge clk) begin
      if (enq) mem[tail] <= e0;
      if (enq2) mem[tail + PTR_W'(1)] <= e1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flash) begin
         head            <= '0;
         tail            <= '0;
         count           <= '0;
         bus.out_valid   <= '0;
         bus.out_payload <= '0;
      end else begin
         head  <= head + PTR_W'(n_deq);
         tail  <= tail + PTR_W'(n_enq);
         count <= count + CNT_W'(n_enq) - CNT_W'(n_deq);
         if (!stall) begin
            bus.out_valid      <= {iss1, iss0};
            bus.out_payload[0] <= iss0 ? q0.payload : 64'd0;
            bus.out_payload[1] <= iss1 ? q1.payload : 64'd0;
         end
      end
   end
endmodule

// File: tb/tb_issue_queue.sv
// Random + directed bench for issue_queue against a queue-level reference model
// and a behavioural score board (shift right per unstalled cycle, slot 1 wins).
module tb_issue_queue;
   localparam int DEPTH = 4;
   localparam int POS_W = 8;
   localparam int RA    = 5;

   logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, flash = 1'b0;
   always #5 clk = ~clk;

   issue_queue_if #(.REG_ADDR(RA), .POS_W(POS_W)) bus();

   issue_queue #(.DEPTH(DEPTH), .POS_W(POS_W), .FWD_LVL(1), .REG_ADDR(RA)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flash(flash), .bus(bus)
   );

   typedef struct {
      logic [RA-1:0] dest;
      logic          wr;
      logic [RA-1:0] rs, rt;
      int            lat;
      logic [63:0]   pl;
   } ins_t;

   typedef struct {
      logic [1:0]  v;
      logic [63:0] p0, p1;
   } exp_t;

   ins_t       mq[$];
   exp_t       eq[$];
   exp_t       last;
   logic [7:0] sb_arr [32];
   logic [7:0] sb_nxt [32];
   int         vectors = 0, miscompares = 0;

   always_comb begin
      for (int k = 0; k < 4; k++) bus.sb_data_out[k] = sb_arr[bus.sb_read_addr[k]];
   end

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic rdy(logic [RA-1:0] r);
      return (r == 0) || (sb_arr[r][7:1] == 7'd0);
   endfunction

   function automatic ins_t mk(int dest, int wr, int rs, int rt, int lat);
      ins_t i;
      i.dest = RA'(dest); i.wr = wr[0]; i.rs = RA'(rs); i.rt = RA'(rt);
      i.lat = lat; i.pl = {$urandom, $urandom};
      return i;
   endfunction

   function automatic ins_t rnd();
      return mk($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                $urandom_range(0, 7), ($urandom_range(0, 3) == 0) ? $urandom_range(2, 5) : 1);
   endfunction

   task automatic drive(logic [1:0] v, ins_t a, ins_t b);
      bus.in_valid = v;
      bus.in_dest[0] = a.dest; bus.in_wr[0] = a.wr; bus.in_src[0][0] = a.rs; bus.in_src[0][1] = a.rt;
      bus.in_lat[0] = 3'(a.lat); bus.in_payload[0] = a.pl;
      bus.in_dest[1] = b.dest; bus.in_wr[1] = b.wr; bus.in_src[1][0] = b.rs; bus.in_src[1][1] = b.rt;
      bus.in_lat[1] = 3'(b.lat); bus.in_payload[1] = b.pl;
   endtask

   // Reference step for one cycle; inputs are already applied.
   task automatic model();
      logic        ready;
      int          n;
      exp_t        e;
      logic [1:0]  ena;
      logic [RA-1:0] addr [2];
      logic [7:0]  pos [2];
      #1;
      ready = !rst_n || (mq.size() <= DEPTH - 2);
      n = 0; ena = 2'b00;
      chk("in_ready", 64'(bus.in_ready), 64'(ready));
      if (!rst_n || flash) begin
         mq.delete();
         e = '{2'b00, 64'd0, 64'd0};
         for (int r = 0; r < 32; r++) sb_nxt[r] = 8'd0;
      end else begin
         if (mq.size() >= 1) begin
            chk("rd_q0_rs", 64'(bus.sb_read_addr[0]), 64'(mq[0].rs));
            chk("rd_q0_rt", 64'(bus.sb_read_addr[1]), 64'(mq[0].rt));
         end
         if (mq.size() >= 2) begin
            chk("rd_q1_rs", 64'(bus.sb_read_addr[2]), 64'(mq[1].rs));
            chk("rd_q1_rt", 64'(bus.sb_read_addr[3]), 64'(mq[1].rt));
         end
         if (!stall && mq.size() >= 1 && rdy(mq[0].rs) && rdy(mq[0].rt)) n = 1;
         if (n == 1 && mq.size() >= 2 && rdy(mq[1].rs) && rdy(mq[1].rt) &&
             !(mq[0].wr && mq[0].dest != 0 && (mq[0].dest == mq[1].rs || mq[0].dest == mq[1].rt)))
            n = 2;
         if (stall) begin
            e = last;
            for (int r = 0; r < 32; r++) sb_nxt[r] = sb_arr[r];
         end else begin
            e.v  = (n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
            e.p0 = (n >= 1) ? mq[0].pl : 64'd0;
            e.p1 = (n == 2) ? mq[1].pl : 64'd0;
            for (int r = 0; r < 32; r++) sb_nxt[r] = sb_arr[r] >> 1;
         end
         for (int k = 0; k < n; k++) begin
            if (mq[k].wr && mq[k].dest != 0) begin
               ena[k] = 1'b1; addr[k] = mq[k].dest; pos[k] = 8'(1 << (mq[k].lat - 1));
               sb_nxt[mq[k].dest] = pos[k];
            end
         end
         for (int k = 0; k < n; k++) void'(mq.pop_front());
         if (ready && bus.in_valid[0]) begin
            mq.push_back(mk(0, 0, 0, 0, 1));
            mq[$] = '{bus.in_dest[0], bus.in_wr[0], bus.in_src[0][0], bus.in_src[0][1],
                      (bus.in_lat[0] == 0) ? 8 : int'(bus.in_lat[0]), bus.in_payload[0]};
            if (bus.in_valid[1])
               mq.push_back('{bus.in_dest[1], bus.in_wr[1], bus.in_src[1][0], bus.in_src[1][1],
                              (bus.in_lat[1] == 0) ? 8 : int'(bus.in_lat[1]), bus.in_payload[1]});
         end
      end
      chk("sb_write_ena", 64'(bus.sb_write_ena), 64'(ena));
      for (int k = 0; k < 2; k++) begin
         if (ena[k]) begin
            chk("sb_write_addr", 64'(bus.sb_write_addr[k]), 64'(addr[k]));
            chk("sb_data_in", 64'(bus.sb_data_in[k]), 64'(pos[k]));
         end
      end
      eq.push_back(e);
      last = e;
   endtask

   task automatic step(logic r, logic s, logic f, logic [1:0] v, ins_t a, ins_t b);
      @(posedge clk);
      #1;
      for (int i = 0; i < 32; i++) sb_arr[i] = sb_nxt[i];
      rst_n = r; stall = s; flash = f;
      drive(v, a, b);
      model();
   endtask

   // Registered-output monitor: one expectation per edge.
   always @(posedge clk) begin : mon
      exp_t x;
      #1;
      if (eq.size() != 0) begin
         x = eq.pop_front();
         chk("out_valid", 64'(bus.out_valid), 64'(x.v));
         chk("out_payload0", bus.out_payload[0], x.p0);
         chk("out_payload1", bus.out_payload[1], x.p1);
      end
   end

   initial begin
      ins_t z;
      logic [1:0] v;
      z = mk(0, 0, 0, 0, 1);
      last = '{2'b00, 64'd0, 64'd0};
      for (int i = 0; i < 32; i++) begin sb_arr[i] = 8'd0; sb_nxt[i] = 8'd0; end
      drive(2'b00, z, z);
      repeat (3) step(1'b0, 1'b0, 1'b0, 2'b00, z, z);
      // independent pair, then RAW pair on r7, then lat-3 load of r8 and its consumer
      step(1'b1, 1'b0, 1'b0, 2'b11, mk(1, 1, 2, 3, 1), mk(4, 1, 5, 6, 1));
      step(1'b1, 1'b0, 1'b0, 2'b00, z, z);
      step(1'b1, 1'b0, 1'b0, 2'b11, mk(7, 1, 1, 2, 1), mk(10, 1, 7, 0, 1));
      repeat (2) step(1'b1, 1'b0, 1'b0, 2'b00, z, z);
      step(1'b1, 1'b0, 1'b0, 2'b01, mk(8, 1, 0, 0, 3), z);
      step(1'b1, 1'b0, 1'b0, 2'b11, mk(11, 1, 8, 1, 1), mk(12, 1, 0, 0, 1));
      step(1'b1, 1'b0, 1'b0, 2'b11, mk(13, 1, 0, 0, 1), mk(14, 1, 0, 0, 1));
      repeat (3) step(1'b1, 1'b1, 1'b0, 2'b00, z, z);
      repeat (4) step(1'b1, 1'b0, 1'b0, 2'b00, z, z);
      // WAW on r9, then a consumer of r9
      step(1'b1, 1'b0, 1'b0, 2'b11, mk(9, 1, 0, 0, 1), mk(9, 1, 0, 0, 3));
      step(1'b1, 1'b0, 1'b0, 2'b11, mk(15, 1, 9, 0, 1), mk(6, 1, 0, 0, 5));
      step(1'b1, 1'b0, 1'b0, 2'b01, mk(5, 1, 6, 0, 1), z);
      step(1'b1, 1'b0, 1'b1, 2'b00, z, z);
      step(1'b1, 1'b0, 1'b0, 2'b11, mk(3, 1, 0, 0, 4), mk(2, 1, 3, 0, 1));
      step(1'b0, 1'b0, 1'b0, 2'b00, z, z);
      for (int c = 0; c < 3000; c++) begin
         case ($urandom_range(0, 2))
            0:       v = 2'b00;
            1:       v = 2'b01;
            default: v = 2'b11;
         endcase
         step(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 49) == 0), v, rnd(), rnd());
      end
      @(posedge clk);
      #2;
      chk("drain", 64'(eq.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
